// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator and the keyboard scanner.
//   - emu_state_e : emulator FSM encoding
//   - KEY_COL_MSB / KEY_ROW_MSB : key-code field positions ([3:2] column, [1:0] row)
//   - ROW_IDLE : all row lines released (active-low)
//   - key_col() / key_row() : field extractors, also used by the scanner's decode table
package keypad_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StPress = 2'd1,
      StGap   = 2'd2
   } emu_state_e;

   localparam int unsigned KEY_COL_MSB = 3;
   localparam int unsigned KEY_ROW_MSB = 1;
   localparam logic [3:0]  ROW_IDLE    = 4'b1111;

   function automatic logic [1:0] key_col(input logic [3:0] code);
      return code[KEY_COL_MSB -: 2];
   endfunction

   function automatic logic [1:0] key_row(input logic [3:0] code);
      return code[KEY_ROW_MSB -: 2];
   endfunction

endpackage

// File: rtl/key_fifo.sv
// Request queue for the keypad emulator.
// Ports:
//   clk_i / rst_ni : clock, asynchronous active-low reset
//   push_i, wdata_i: write request and data; taken when not full, or when full and a pop
//                    is taken in the same cycle
//   pop_i          : read request; taken when not empty, rdata_o shows the head entry
//   full_o, empty_o: occupancy flags
module key_fifo #(
   parameter int unsigned Width = 4,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Width-1:0] mem_q [Depth];
   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
   logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
   logic             push_ok, pop_ok;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                    (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

   assign pop_ok  = pop_i && !empty_o;
   // When full, the slot being popped this cycle is the one written.
   assign push_ok = push_i && (!full_o || pop_ok);

   assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AddrW{1'b0}}, push_ok};
      rd_ptr_d = rd_ptr_q + {{AddrW{1'b0}}, pop_ok};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Plays queued key codes onto a passive 4x4 active-low row/column matrix so the keyboard
// scanner can be exercised without a physical keypad. Each key is held HOLD_CYCLES, then
// released for GAP_CYCLES.
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   key_code_i, key_valid_i  : key request ([3:2] column, [1:0] row), pushed when valid
//   key_ready_o              : request queue not full
//   col_i                    : scanner column strobes, active-low
//   row_o                    : row lines to scanner, active-low, combinational in col_i
//   pressed_o                : key contact currently closed
//   busy_o                   : playing a key or requests pending
//   sent_count_o             : completed presses, wraps
// Build option: define KEYPAD_EMU_BOUNCE_EN to model contact bounce at the start of each
// press and release (BOUNCE_CYCLES window, toggling every 2048 clocks).
module keypad_matrix_emulator
   import keypad_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES   = 10_000_000,
   parameter int unsigned GAP_CYCLES    = 10_000_000,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned BOUNCE_CYCLES = 50_000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [3:0] key_code_i,
   input  logic       key_valid_i,
   output logic       key_ready_o,
   input  logic [3:0] col_i,
   output logic [3:0] row_o,
   output logic       pressed_o,
   output logic       busy_o,
   output logic [7:0] sent_count_o
);

   localparam int unsigned MaxCycles = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
   localparam logic [TimerW-1:0] HoldLoad = TimerW'(HOLD_CYCLES - 1);
   localparam logic [TimerW-1:0] GapLoad  = TimerW'(GAP_CYCLES - 1);

   emu_state_e        state_q, state_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [3:0]        cur_key_q, cur_key_d;
   logic [7:0]        sent_q, sent_d;

   logic       fifo_pop;
   logic       fifo_full, fifo_empty;
   logic [3:0] fifo_rdata;
   logic       contact;

   key_fifo #(
      .Width (4),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (key_valid_i),
      .wdata_i (key_code_i),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // FSM next state and timer
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      cur_key_d = cur_key_q;
      sent_d    = sent_q;
      fifo_pop  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               cur_key_d = fifo_rdata;
               timer_d   = HoldLoad;
               state_d   = StPress;
            end
         end
         StPress: begin
            if (timer_q == '0) begin
               sent_d  = sent_q + 8'd1;
               timer_d = GapLoad;
               state_d = StGap;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         StGap: begin
            if (timer_q == '0) begin
               state_d = StIdle;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         cur_key_q <= '0;
         sent_q    <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         cur_key_q <= cur_key_d;
         sent_q    <= sent_d;
      end
   end

`ifdef KEYPAD_EMU_BOUNCE_EN
   // Timer counts down from HOLD/GAP-1, so the first BOUNCE_CYCLES of a phase are the
   // timer values at or above LOAD+1-BOUNCE_CYCLES.
   localparam logic [TimerW-1:0] PressBounceEnd = TimerW'(HOLD_CYCLES - BOUNCE_CYCLES);
   localparam logic [TimerW-1:0] GapBounceEnd   = TimerW'(GAP_CYCLES - BOUNCE_CYCLES);

   logic [10:0] bounce_cnt_q;
   logic        bounce_q, bounce_d;
   logic        in_window;

   always_comb begin
      in_window = 1'b0;
      case (state_q)
         StPress: in_window = (timer_q >= PressBounceEnd);
         StGap:   in_window = (timer_q >= GapBounceEnd);
         default: in_window = 1'b0;
      endcase
      bounce_d = bounce_q;
      if (state_d != state_q) begin
         // Each phase starts in the opposite of its nominal contact state.
         bounce_d = (state_d == StGap);
      end else if (bounce_cnt_q == '1) begin
         bounce_d = ~bounce_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bounce_cnt_q <= '0;
         bounce_q     <= 1'b0;
      end else begin
         bounce_cnt_q <= bounce_cnt_q + 11'd1;
         bounce_q     <= bounce_d;
      end
   end

   assign contact = in_window ? bounce_q : (state_q == StPress);
`else
   logic unused_bounce_cfg;
   assign unused_bounce_cfg = ^BOUNCE_CYCLES;
   assign contact = (state_q == StPress);
`endif

   // Row model: pull the key's row low only while its column is strobed.
   always_comb begin
      row_o = ROW_IDLE;
      if (contact && !col_i[key_col(cur_key_q)]) begin
         row_o[key_row(cur_key_q)] = 1'b0;
      end
   end

   assign pressed_o    = (state_q == StPress) && contact;
   assign busy_o       = (state_q != StIdle) || !fifo_empty;
   assign key_ready_o  = !fifo_full;
   assign sent_count_o = sent_q;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
module tb_keypad_matrix_emulator;

   localparam int unsigned HOLD  = 8;
   localparam int unsigned GAP   = 4;
   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] key_code = 4'h0;
   logic       key_valid = 1'b0;
   logic [3:0] col = 4'b0000;
   logic       key_ready;
   logic [3:0] row;
   logic       pressed;
   logic       busy;
   logic [7:0] sent_count;

   always #5 clk = ~clk;

   keypad_matrix_emulator #(
      .HOLD_CYCLES   (HOLD),
      .GAP_CYCLES    (GAP),
      .FIFO_DEPTH    (DEPTH),
      .BOUNCE_CYCLES (4096)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .key_code_i   (key_code),
      .key_valid_i  (key_valid),
      .key_ready_o  (key_ready),
      .col_i        (col),
      .row_o        (row),
      .pressed_o    (pressed),
      .busy_o       (busy),
      .sent_count_o (sent_count)
   );

   int compared = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] exp_row(input bit closed, input logic [3:0] k,
                                          input logic [3:0] c);
      logic [3:0] r;
      r = 4'b1111;
      if (closed && c[k[3:2]] == 1'b0) r[k[1:0]] = 1'b0;
      return r;
   endfunction

   // Reference model: a queue of pending keys and a countdown of cycles the player is
   // still occupied after taking a key (HOLD pressed + GAP released).
   logic [3:0] m_q[$];
   logic [3:0] exp_q[$];
   int         m_left = 0;
   logic [7:0] m_cnt = 8'd0;
   bit         m_acc = 1'b0;
   bit         m_pop;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         exp_q.delete();
         m_left = 0;
         m_cnt  = 8'd0;
         m_acc  = 1'b0;
      end else begin
         m_pop = (m_left == 0) && (m_q.size() > 0);
         m_acc = key_valid && ((m_q.size() < DEPTH) || m_pop);
         if (m_pop) begin
            void'(m_q.pop_front());
            m_left = HOLD + GAP;
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == GAP) m_cnt++;
         end
         if (m_acc) begin
            m_q.push_back(key_code);
            exp_q.push_back(key_code);
         end
      end
   end

   // Monitor: takes the next expected key when a press appears, checks all outputs.
   logic       prev_pressed = 1'b0;
   logic [3:0] mon_key = 4'h0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (pressed && !prev_pressed) begin
            check("press_has_expected_key", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) mon_key = exp_q.pop_front();
         end
         check("pressed", pressed, (m_left > GAP));
         check("busy", busy, ((m_left > 0) || (m_q.size() > 0)));
         check("key_ready", key_ready, (m_q.size() < DEPTH));
         check("sent_count", sent_count, m_cnt);
         check("row", row, exp_row(m_left > GAP, mon_key, col));
         prev_pressed = pressed;
      end else begin
         prev_pressed = 1'b0;
      end
   end

   bit rand_col = 1'b0;
   always @(posedge clk) begin
      if (rand_col) begin
         #1;
         col = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      end
   end

   task automatic push_key(input logic [3:0] code);
      int guard;
      guard = 0;
      key_valid = 1'b1;
      key_code  = code;
      do begin
         @(posedge clk);
         #1;
         guard++;
      end while (!m_acc && guard < 200);
      if (!m_acc) begin
         compared++;
         mismatched++;
         $display("FAIL push_timeout: got not accepted, expected accepted (t=%0t)", $time);
      end
      key_valid = 1'b0;
      key_code  = 4'($urandom);
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while ((m_left > 0 || m_q.size() > 0) && guard < 5000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      wait_cycles(2);
      check("idle_reached", (m_left == 0 && m_q.size() == 0), 1);
      check("idle_busy", busy, 0);
   endtask

   task automatic wait_pressed();
      int guard;
      guard = 0;
      while (!(m_left > GAP) && guard < 500) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("press_started", (m_left > GAP), 1);
   endtask

   logic [3:0] walk [4];

   initial begin
      walk[0] = 4'b1110;
      walk[1] = 4'b1101;
      walk[2] = 4'b1011;
      walk[3] = 4'b0111;

      // Reset values
      #1;
      check("rst_row", row, 4'b1111);
      check("rst_pressed", pressed, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", key_ready, 1);
      check("rst_count", sent_count, 0);
      wait_cycles(2);
      rst_n = 1'b1;
      wait_cycles(1);

      // Single key 5: row 1 low while col idle strobe is 0000
      push_key(4'h5);
      wait_idle();
      check("count_after_5", sent_count, 1);

      // Key E with walking column strobe
      push_key(4'hE);
      wait_pressed();
      for (int i = 0; i < 4; i++) begin
         col = walk[i];
         @(negedge clk);
         check("walk_row", row, (i == 3) ? 4'b1011 : 4'b1111);
         @(posedge clk);
         #1;
      end
      col = 4'b0000;
      wait_idle();

      // Back-to-back pushes filling the queue
      for (int k = 0; k < 6; k++) push_key(4'(k));
      wait_idle();

      // Reset mid-press of F with a key still queued
      push_key(4'hF);
      push_key(4'h3);
      wait_pressed();
      wait_cycles(3);
      rst_n = 1'b0;
      #1;
      check("midrst_row", row, 4'b1111);
      check("midrst_pressed", pressed, 0);
      check("midrst_busy", busy, 0);
      check("midrst_count", sent_count, 0);
      check("midrst_ready", key_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_cycles(3);
      check("postrst_busy", busy, 0);

      // Randomized run long enough to wrap sent_count; FIFO stays full so pushes
      // coincide with pops.
      rand_col = 1'b1;
      for (int k = 0; k < 262; k++) begin
         push_key(4'($urandom));
         if ($urandom_range(0, 7) == 0) wait_cycles($urandom_range(1, 20));
      end
      wait_idle();
      rand_col = 1'b0;
      #2;
      col = 4'b0000;
      check("wrap_count", sent_count, 8'd6);
      check("all_keys_played", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, expected finish (t=%0t)", $time);
      $fatal(1, "timeout");
   end

endmodule
